// File: rtl/skew_count_pkg.sv
// Shared definitions for the ripple-counter skew monitor.
package skew_count_pkg;

    // Width of the monitored ripple counter.
    localparam int CNT_W = 4;

    // Lock/settle tracking states.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SETTLING = 2'd1,
        STABLE   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic CLK,
    input  logic PRE,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a cycle to resolve metastability.
    always_ff @(posedge CLK or posedge PRE) begin
        if (PRE) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/skew_count_monitor.sv
// Samples an asynchronous ripple counter, waits for its bits to settle, and
// reports accepted values, sequence errors and abandoned intermediate values.
module skew_count_monitor
    import skew_count_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             PRE,
    input  logic             sQ0,
    input  logic             sQ1,
    input  logic             sQ2,
    input  logic             sQ3,
    output logic [3:0]       count,
    output logic             count_valid,
    output logic             seq_err,
    output logic             glitch,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] s_q;
    logic [CNT_W-1:0] cand;
    logic [3:0]       stab_cnt;
    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             seq_bad;
    logic             glitch_det;

    sync_2ff u_sync0 (.CLK(CLK), .PRE(PRE), .d(sQ0), .q(s_q[0]));
    sync_2ff u_sync1 (.CLK(CLK), .PRE(PRE), .d(sQ1), .q(s_q[1]));
    sync_2ff u_sync2 (.CLK(CLK), .PRE(PRE), .d(sQ2), .q(s_q[2]));
    sync_2ff u_sync3 (.CLK(CLK), .PRE(PRE), .d(sQ3), .q(s_q[3]));

    // Acceptance, sequence and glitch conditions derived from the current sample.
    always_comb begin
        accept     = (s_q == cand) && (stab_cnt == STAB_MAX) &&
                     ((cand != count) || (state == UNLOCKED));
        seq_bad    = locked && (cand != (count + 4'd1));
        glitch_det = (state == SETTLING) && (s_q != cand) &&
                     (s_q != count) && (cand != count);
    end

    // Next-state logic: settle whenever the sample leaves the accepted value.
    always_comb begin
        state_next = state;
        case (state)
            UNLOCKED: if (accept) state_next = STABLE;
            STABLE:   if (s_q != count) state_next = SETTLING;
            SETTLING: if (accept || (s_q == count)) state_next = STABLE;
            default:  state_next = UNLOCKED;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge PRE) begin
        if (PRE) state <= UNLOCKED;
        else     state <= state_next;
    end

    // Candidate tracking: restart the stability count whenever the sample moves.
    always_ff @(posedge CLK or posedge PRE) begin
        if (PRE) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (s_q != cand) begin
            cand     <= s_q;
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 4'd1;
        end
    end

    // Registered outputs; pulses are raised for one cycle after the triggering edge.
    always_ff @(posedge CLK or posedge PRE) begin
        if (PRE) begin
            count       <= '0;
            count_valid <= 1'b0;
            seq_err     <= 1'b0;
            glitch      <= 1'b0;
            err_count   <= '0;
            locked      <= 1'b0;
        end else begin
            count_valid <= accept;
            seq_err     <= accept && seq_bad;
            glitch      <= glitch_det;
            if (accept) begin
                count  <= cand;
                locked <= 1'b1;
            end
            if (accept && seq_bad && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_skew_count_monitor.sv
// Scoreboard bench for skew_count_monitor: stimulus pushes expected updates,
// a negedge monitor pops and compares them whenever count_valid pulses.
module tb_skew_count_monitor;

    typedef struct packed {
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    logic       CLK;
    logic       PRE;
    logic [3:0] sq;

    logic [3:0] count;
    logic       countValid;
    logic       seqErr;
    logic       glitch;
    logic [7:0] errCount;
    logic       locked;

    logic [3:0] satCount;
    logic       satCountValid;
    logic       satSeqErr;
    logic       satGlitch;
    logic [1:0] satErrCount;
    logic       satLocked;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   glitchSeen  = 0;

    skew_count_monitor #(.STABLE_CYCLES(3), .ERR_W(8)) dut (
        .CLK(CLK), .PRE(PRE),
        .sQ0(sq[0]), .sQ1(sq[1]), .sQ2(sq[2]), .sQ3(sq[3]),
        .count(count), .count_valid(countValid), .seq_err(seqErr),
        .glitch(glitch), .err_count(errCount), .locked(locked)
    );

    skew_count_monitor #(.STABLE_CYCLES(3), .ERR_W(2)) dutSat (
        .CLK(CLK), .PRE(PRE),
        .sQ0(sq[0]), .sQ1(sq[1]), .sQ2(sq[2]), .sQ3(sq[3]),
        .count(satCount), .count_valid(satCountValid), .seq_err(satSeqErr),
        .glitch(satGlitch), .err_count(satErrCount), .locked(satLocked)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Change the counter input just after a clock edge, hold it, and queue the expected update.
    task automatic applyStimulus(input logic [3:0] value, input int holdCycles,
                                 input bit expectAccept, input bit expectErr);
        exp_t e;
        @(posedge CLK);
        #1;
        sq = value;
        if (expectAccept) begin
            e.cnt = value;
            e.err = expectErr;
            expQ.push_back(e);
        end
        repeat (holdCycles - 1) @(posedge CLK);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, int'(count), 0);
        checkOutput({tag, "_count_valid"}, int'(countValid), 0);
        checkOutput({tag, "_seq_err"}, int'(seqErr), 0);
        checkOutput({tag, "_glitch"}, int'(glitch), 0);
        checkOutput({tag, "_err_count"}, int'(errCount), 0);
        checkOutput({tag, "_locked"}, int'(locked), 0);
        checkOutput({tag, "_sat_err_count"}, int'(satErrCount), 0);
    endtask

    // Monitor: every count_valid must match the oldest queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!PRE) begin
            if (glitch) glitchSeen++;
            if (countValid) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_count_valid: got count %0d, expected no update", count);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("update_count", int'(count), int'(e.cnt));
                    checkOutput("update_seq_err", int'(seqErr), int'(e.err));
                end
            end else if (seqErr) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL lone_seq_err: got seq_err 1 without count_valid, expected 0");
            end
        end
    end

    initial begin
        int glitchBefore;
        PRE = 1'b1;
        sq  = 4'd0;

        // Reset with inputs at zero.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkResetState("reset");
        @(posedge CLK);
        #1;
        PRE = 1'b0;
        expQ.push_back(exp_t'({4'd0, 1'b0}));
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        checkOutput("first_lock_locked", int'(locked), 1);
        checkOutput("first_lock_count", int'(count), 0);
        checkOutput("first_lock_err_count", int'(errCount), 0);

        // Clean counting 1..15 then wrap to 0.
        for (int v = 1; v <= 16; v++) applyStimulus(4'(v), 5, 1'b1, 1'b0);
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        checkOutput("clean_pending_updates", expQ.size(), 0);
        checkOutput("clean_count", int'(count), 0);
        checkOutput("clean_err_count", int'(errCount), 0);

        // Skip from 3 to 5.
        applyStimulus(4'd1, 5, 1'b1, 1'b0);
        applyStimulus(4'd2, 5, 1'b1, 1'b0);
        applyStimulus(4'd3, 8, 1'b1, 1'b0);
        applyStimulus(4'd5, 10, 1'b1, 1'b1);
        @(negedge CLK);
        checkOutput("skip_count", int'(count), 5);
        checkOutput("skip_err_count", int'(errCount), 1);
        checkOutput("skip_sat_err_count", int'(satErrCount), 1);

        // Ripple glitch from 7 through 6,4,0 into 8.
        applyStimulus(4'd6, 5, 1'b1, 1'b0);
        applyStimulus(4'd7, 8, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("pre_glitch_count", int'(count), 7);
        glitchBefore = glitchSeen;
        applyStimulus(4'd6, 1, 1'b0, 1'b0);
        applyStimulus(4'd4, 1, 1'b0, 1'b0);
        applyStimulus(4'd0, 1, 1'b0, 1'b0);
        applyStimulus(4'd8, 10, 1'b1, 1'b0);
        @(negedge CLK);
        checkOutput("glitch_pulsed", int'(glitchSeen > glitchBefore), 1);
        checkOutput("glitch_count", int'(count), 8);
        checkOutput("glitch_err_count", int'(errCount), 1);

        // Reset while settling toward 12.
        applyStimulus(4'd12, 4, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        PRE = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkResetState("mid_reset");
        @(posedge CLK);
        #1;
        PRE = 1'b0;
        expQ.push_back(exp_t'({4'd12, 1'b0}));
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        checkOutput("relock_locked", int'(locked), 1);
        checkOutput("relock_count", int'(count), 12);
        checkOutput("relock_err_count", int'(errCount), 0);

        // Skip to 9, then a one-cycle bounce to 10 and back.
        applyStimulus(4'd9, 10, 1'b1, 1'b1);
        applyStimulus(4'd10, 1, 1'b0, 1'b0);
        applyStimulus(4'd9, 10, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("bounce_count", int'(count), 9);
        checkOutput("bounce_err_count", int'(errCount), 1);

        // Further skips drive the narrow error counter into saturation.
        applyStimulus(4'd11, 10, 1'b1, 1'b1);
        applyStimulus(4'd14, 10, 1'b1, 1'b1);
        applyStimulus(4'd1, 10, 1'b1, 1'b1);
        @(negedge CLK);
        checkOutput("sat_err_count_reach", int'(satErrCount), 3);
        applyStimulus(4'd5, 10, 1'b1, 1'b1);
        @(negedge CLK);
        checkOutput("sat_err_count_hold", int'(satErrCount), 3);
        checkOutput("wide_err_count", int'(errCount), 5);
        checkOutput("final_count", int'(count), 5);
        checkOutput("final_pending_updates", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
